// File: rtl/scan_sel_generator.sv
// Scan select generator: prescaled up/down 3-bit select counter with wrap at LAST.
// Optional decoder blanking in the last prescale cycle of each step is enabled by `define SCAN_BLANK_EN.
module scan_sel_generator #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       dir_i,
    input  logic       load_i,
    input  logic [2:0] load_val_i,
    input  logic [2:0] last_i,
    output logic [2:0] sel_o,
    output logic       tick_o,
    output logic       wrap_o,
    output logic       blank_o
);

    localparam int unsigned   PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);

`ifdef SCAN_BLANK_EN
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_BLANK} state_t;
`else
    typedef enum logic {ST_IDLE, ST_RUN} state_t;
`endif

    state_t        state_q, state_d, run_state;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [2:0]    sel_q, sel_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;
    logic          step;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            pcnt_q  <= '0;
            sel_q   <= 3'd0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            sel_q   <= sel_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    // Prescaler and select stepping; LOAD overrides everything else.
    always_comb begin
        pcnt_d = pcnt_q;
        sel_d  = sel_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        step   = 1'b0;
        if (load_i) begin
            sel_d  = load_val_i;
            pcnt_d = '0;
        end else if (en_i) begin
            if (pcnt_q == PCNT_MAX) begin
                pcnt_d = '0;
                step   = 1'b1;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end
        if (step) begin
            tick_d = 1'b1;
            if (!dir_i) begin
                if (sel_q >= last_i) begin
                    sel_d  = 3'd0;
                    wrap_d = 1'b1;
                end else begin
                    sel_d = sel_q + 3'd1;
                end
            end else begin
                // An out-of-range select snaps back to LAST when counting down.
                if (sel_q == 3'd0 || sel_q > last_i) begin
                    sel_d  = last_i;
                    wrap_d = 1'b1;
                end else begin
                    sel_d = sel_q - 3'd1;
                end
            end
        end
    end

`ifdef SCAN_BLANK_EN
    logic blank_cycle;
    assign blank_cycle = (PRESCALE > 1) && en_i && !load_i && (pcnt_d == PCNT_MAX);
    assign run_state   = blank_cycle ? ST_BLANK : ST_RUN;
    assign blank_o     = (state_q == ST_BLANK);
`else
    assign run_state   = ST_RUN;
    assign blank_o     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en_i) state_d = run_state;
            default: state_d = en_i ? run_state : ST_IDLE;
        endcase
    end

    assign sel_o  = sel_q;
    assign tick_o = tick_q;
    assign wrap_o = wrap_q;

endmodule
